// File: rtl/fc_head_sequencer_if.sv
// fc_head_sequencer_if: vector intake, dense1/dense2 layer links and class result handshake.
interface fc_head_sequencer_if #(
  parameter int IN_SIZE  = 1568,
  parameter int HID_SIZE = 128,
  parameter int OUT_SIZE = 10,
  parameter int DATA_W   = 8
);
  localparam int KW = $clog2(OUT_SIZE);
  logic in_valid, in_ready;
  logic [IN_SIZE*DATA_W-1:0] in_vec, l1_in_vec;
  logic l1_start, l1_out_valid, l2_start, l2_out_valid;
  logic [HID_SIZE*DATA_W-1:0] l1_out_vec, l2_in_vec;
  logic [OUT_SIZE*DATA_W-1:0] l2_out_vec;
  logic result_valid, result_ready;
  logic [KW-1:0] class_idx;
  logic signed [DATA_W-1:0] class_score;
  modport master (
    output in_valid, in_vec, l1_out_vec, l1_out_valid, l2_out_vec, l2_out_valid, result_ready,
    input  in_ready, l1_start, l1_in_vec, l2_start, l2_in_vec, result_valid, class_idx, class_score
  );
  modport slave (
    input  in_valid, in_vec, l1_out_vec, l1_out_valid, l2_out_vec, l2_out_valid, result_ready,
    output in_ready, l1_start, l1_in_vec, l2_start, l2_in_vec, result_valid, class_idx, class_score
  );
endinterface

// File: rtl/fc_head_sequencer.sv
// fc_head_sequencer: sequences dense1/dense2, owns their buffers, argmaxes the logits,
// and guards each layer with a watchdog; counts completed inferences.
module fc_head_sequencer #(
  parameter int IN_SIZE        = 1568,
  parameter int HID_SIZE       = 128,
  parameter int OUT_SIZE       = 10,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 262143
) (
  input  logic        clk,
  input  logic        rst_n,
  fc_head_sequencer_if.slave bus,
  output logic        busy,
  output logic        error,
  input  logic        err_clr,
  output logic [15:0] infer_count
);
  localparam int KW = $clog2(OUT_SIZE);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, L1_START, L1_WAIT, L2_START, L2_WAIT, ARGMAX, RESULT, ERROR} state_t;
  state_t state_q, state_d;
  logic in_ready_q, l1_start_q, l2_start_q, result_valid_q, busy_q, error_q;
  logic [WW-1:0] wd_q, wd_d;
  logic [KW-1:0] k_q, k_d, idx_q, idx_d;
  logic signed [DATA_W-1:0] best_q, best_d, cur;
  logic [15:0] infer_count_q, infer_count_d;
  logic [IN_SIZE*DATA_W-1:0] feat_q, feat_d;
  logic [HID_SIZE*DATA_W-1:0] hid_q, hid_d;
  logic [OUT_SIZE*DATA_W-1:0] logit_q, logit_d;
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    k_d = k_q;
    idx_d = idx_q;
    best_d = best_q;
    infer_count_d = infer_count_q;
    feat_d = feat_q;
    hid_d = hid_q;
    logit_d = logit_q;
    cur = logit_q[int'(k_q)*DATA_W +: DATA_W];
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        feat_d = bus.in_vec;
        state_d = L1_START;
      end
      L1_START: begin
        wd_d = '0;
        state_d = L1_WAIT;
      end
      L1_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.l1_out_valid) begin
          hid_d = bus.l1_out_vec;
          state_d = L2_START;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      end
      L2_START: begin
        wd_d = '0;
        state_d = L2_WAIT;
      end
      L2_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.l2_out_valid) begin
          logit_d = bus.l2_out_vec;
          best_d = bus.l2_out_vec[DATA_W-1:0];
          idx_d = '0;
          k_d = KW'(1);
          state_d = ARGMAX;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      end
      ARGMAX: begin
        // strict compare keeps the lowest index on ties
        if (cur > best_q) begin
          best_d = cur;
          idx_d = k_q;
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(OUT_SIZE - 1)) state_d = RESULT;
      end
      RESULT: if (bus.result_ready && result_valid_q) begin
        infer_count_d = infer_count_q + 1'b1;
        state_d = IDLE;
      end
      ERROR: if (err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      l1_start_q <= 1'b0;
      l2_start_q <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
      wd_q <= '0;
      k_q <= '0;
      idx_q <= '0;
      best_q <= '0;
      infer_count_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= state_d == IDLE;
      l1_start_q <= state_d == L1_START;
      l2_start_q <= state_d == L2_START;
      result_valid_q <= state_d == RESULT;
      busy_q <= !(state_d inside {IDLE, ERROR});
      error_q <= state_d == ERROR;
      wd_q <= wd_d;
      k_q <= k_d;
      idx_q <= idx_d;
      best_q <= best_d;
      infer_count_q <= infer_count_d;
    end
  // data buffers carry no reset
  always_ff @(posedge clk) begin
    feat_q <= feat_d;
    hid_q <= hid_d;
    logit_q <= logit_d;
  end
  assign bus.in_ready = in_ready_q;
  assign bus.l1_start = l1_start_q;
  assign bus.l2_start = l2_start_q;
  assign bus.l1_in_vec = feat_q;
  assign bus.l2_in_vec = hid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.class_idx = idx_q;
  assign bus.class_score = best_q;
  assign busy = busy_q;
  assign error = error_q;
  assign infer_count = infer_count_q;
endmodule
